// File: rtl/sparse_coo_encoder_if.sv
// +--------------------------------------------------------------------------+
// | sparse_coo_encoder_if: pixel stream in, streamed entries + COO buses out |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sparse_coo_encoder_if #(
  parameter int dataRowNum       = 28,
  parameter int wordLength       = 8,
  parameter int doublewordLength = 16
);
  localparam int BUS_W = dataRowNum * dataRowNum * wordLength;

  logic                        in_valid;
  logic [wordLength-1:0]       pixel_in;
  logic                        in_ready;
  logic                        entry_valid;
  logic [wordLength-1:0]       entry_value;
  logic [wordLength-1:0]       entry_row;
  logic [wordLength-1:0]       entry_col;
  logic                        out_valid;
  logic [doublewordLength-1:0] feacture_valid_num;
  logic [BUS_W-1:0]            feacture_value;
  logic [BUS_W-1:0]            feacture_cols;
  logic [BUS_W-1:0]            feacture_rows;

  // master is the encoder (producer of the feacture_* side)
  modport master (
    input  in_valid, pixel_in,
    output in_ready, entry_valid, entry_value, entry_row, entry_col,
    output out_valid, feacture_valid_num, feacture_value, feacture_cols, feacture_rows
  );

  modport slave (
    output in_valid, pixel_in,
    input  in_ready, entry_valid, entry_value, entry_row, entry_col,
    input  out_valid, feacture_valid_num, feacture_value, feacture_cols, feacture_rows
  );
endinterface

`default_nettype wire

// File: rtl/sparse_coo_encoder.sv
// +--------------------------------------------------------------------------+
// | sparse_coo_encoder: raster-order dense frame to COO value/row/col buses  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sparse_coo_encoder #(
  parameter int dataRowNum       = 28,
  parameter int wordLength       = 8,
  parameter int doublewordLength = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sparse_coo_encoder_if.master bus
);
  localparam int BUS_W = dataRowNum * dataRowNum * wordLength;
  localparam logic [wordLength-1:0] LAST = wordLength'(dataRowNum - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state, state_next;
  logic                        in_ready, out_valid;
  logic                        accept, nonzero, last_pixel;
  logic [wordLength-1:0]       row, col;
  logic [doublewordLength-1:0] count, slot;
  logic [BUS_W-1:0]            value_bus, rows_bus, cols_bus;
  logic                        entry_valid;
  logic [wordLength-1:0]       entry_value, entry_row, entry_col;

  assign accept     = bus.in_valid && in_ready;
  assign nonzero    = |bus.pixel_in;
  assign last_pixel = accept && (row == LAST) && (col == LAST);
  // the first pixel of a frame always lands in slot 0, whatever the old count was
  assign slot       = (state == IDLE) ? '0 : count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (accept) state_next = last_pixel ? DONE : SCAN;
      end
      SCAN: begin
        in_ready = !rst;
        if (last_pixel) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      count       <= '0;
      value_bus   <= '0;
      rows_bus    <= '0;
      cols_bus    <= '0;
      entry_valid <= 1'b0;
      entry_value <= '0;
      entry_row   <= '0;
      entry_col   <= '0;
    end else begin
      entry_valid <= accept && nonzero;
      if (accept) begin
        if (state == IDLE) begin
          count     <= '0;
          value_bus <= '0;
          rows_bus  <= '0;
          cols_bus  <= '0;
        end
        // later slice writes override the frame-start clear above
        if (nonzero) begin
          value_bus[slot*wordLength +: wordLength] <= bus.pixel_in;
          rows_bus[slot*wordLength +: wordLength]  <= row;
          cols_bus[slot*wordLength +: wordLength]  <= col;
          count       <= slot + 1'b1;
          entry_value <= bus.pixel_in;
          entry_row   <= row;
          entry_col   <= col;
        end
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready           = in_ready;
  assign bus.out_valid          = out_valid;
  assign bus.entry_valid        = entry_valid;
  assign bus.entry_value        = entry_value;
  assign bus.entry_row          = entry_row;
  assign bus.entry_col          = entry_col;
  assign bus.feacture_valid_num = count;
  assign bus.feacture_value     = value_bus;
  assign bus.feacture_rows      = rows_bus;
  assign bus.feacture_cols      = cols_bus;

endmodule

`default_nettype wire

// File: tb/tb_sparse_coo_encoder.sv
// Self-checking bench for sparse_coo_encoder: frame-level reference model plus pinned literals.
`default_nettype none

module tb_sparse_coo_encoder;
  localparam int N  = 28;
  localparam int W  = 8;
  localparam int DW = 16;
  localparam int NN = N * N;
  localparam int BW = NN * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sparse_coo_encoder_if #(.dataRowNum(N), .wordLength(W), .doublewordLength(DW)) bus ();

  sparse_coo_encoder #(.dataRowNum(N), .wordLength(W), .doublewordLength(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int t0         = 0;
  int ent_q[$];
  int ov_q[$];

  // Reference model: position in frame is a flat pixel index, coordinates come from div/mod.
  int          m_p    = 0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [BW-1:0] m_val  = '0;
  logic [BW-1:0] m_rows = '0;
  logic [BW-1:0] m_cols = '0;
  bit          m_ev   = 1'b0;
  logic [7:0]  m_ev_val, m_ev_row, m_ev_col;

  always @(posedge clk) begin : model
    bit         acc;
    logic [7:0] v;
    int         r, c;
    cyc = cyc + 1;
    if (rst) begin
      m_p = 0; m_done = 1'b0; m_cnt = 0; m_ev = 1'b0;
      m_val = '0; m_rows = '0; m_cols = '0;
    end else begin
      acc    = bus.in_valid && !m_done;
      v      = bus.pixel_in;
      m_done = 1'b0;
      m_ev   = 1'b0;
      if (acc) begin
        if (m_p == 0) begin
          m_cnt = 0; m_val = '0; m_rows = '0; m_cols = '0;
        end
        r = m_p / N;
        c = m_p % N;
        if (v != 8'd0) begin
          m_val[m_cnt*W +: W]  = v;
          m_rows[m_cnt*W +: W] = 8'(r);
          m_cols[m_cnt*W +: W] = 8'(c);
          m_cnt    = m_cnt + 1;
          m_ev     = 1'b1;
          m_ev_val = v;
          m_ev_row = 8'(r);
          m_ev_col = 8'(c);
        end
        m_p = m_p + 1;
        if (m_p == NN) begin
          m_p    = 0;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      for (int k = 0; k < NN; k++) begin
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s slot %0d: got %0h expected %0h (cycle %0d)",
                   name, k, act[k*W +: W], exp[k*W +: W], cyc);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, !m_done && !rst);
    chk("out_valid", bus.out_valid, m_done);
    chk("entry_valid", bus.entry_valid, m_ev);
    if (m_ev) begin
      chk("entry_value", bus.entry_value, m_ev_val);
      chk("entry_row", bus.entry_row, m_ev_row);
      chk("entry_col", bus.entry_col, m_ev_col);
    end
    if (m_p == 0) chk("valid_num", bus.feacture_valid_num, m_cnt);
    chk_bus("feacture_value", bus.feacture_value, m_val);
    chk_bus("feacture_rows", bus.feacture_rows, m_rows);
    chk_bus("feacture_cols", bus.feacture_cols, m_cols);
    if (bus.entry_valid) ent_q.push_back(cyc - t0);
    if (bus.out_valid)   ov_q.push_back(cyc - t0);
  end

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      1:       return (r == 0 && c == 0) ? 8'h05 : ((r == N-1 && c == N-1) ? 8'h80 : 8'h00);
      2:       return 8'(((r * N + c) % 255) + 1);
      3:       return ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Holds the pixel until the model says it was taken; returns #1 after the accepting edge.
  task automatic send_pixel(input logic [7:0] v, input int bub);
    int guard = 0;
    while (bub > 0 && $urandom_range(99) < bub) begin
      bus.in_valid = 1'b0;
      bus.pixel_in = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.pixel_in = v;
    forever begin
      bit rdy;
      rdy = !m_done && !rst;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 8) begin
        $display("FAIL send_pixel: never accepted (cycle %0d)", cyc);
        $fatal(1);
      end
    end
  endtask

  task automatic frame(input int kind, input int bub, input int abort_at);
    for (int p = 0; p < NN; p++) begin
      if (p == abort_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      send_pixel(pix(kind, p / N, p % N), bub);
      if (p == 0) t0 = cyc - 1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_q();
    ent_q.delete();
    ov_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.pixel_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    chk("post_rst_out_valid", bus.out_valid, 1'b0);
    chk("post_rst_valid_num", bus.feacture_valid_num, 0);
    chk("post_rst_entry_valid", bus.entry_valid, 1'b0);

    // all-zero frame
    clear_q();
    frame(0, 0, -1);
    @(negedge clk); #1;
    chk("zero_out_valid", bus.out_valid, 1'b1);
    chk("zero_count", bus.feacture_valid_num, 0);
    chk("zero_entries", ent_q.size(), 0);
    chk("zero_ov_count", ov_q.size(), 1);
    if (ov_q.size() == 1) chk("zero_ov_cycle", ov_q[0], 784);

    // two nonzeros at the corners
    clear_q();
    frame(1, 0, -1);
    @(negedge clk); #1;
    chk("two_count", bus.feacture_valid_num, 2);
    chk("two_value", bus.feacture_value[15:0], 16'h8005);
    chk("two_rows", bus.feacture_rows[15:0], 16'h1B00);
    chk("two_cols", bus.feacture_cols[15:0], 16'h1B00);
    chk("two_slot2", bus.feacture_value[23:16], 8'h00);
    chk("two_entries", ent_q.size(), 2);
    if (ent_q.size() == 2) begin
      chk("two_entry0_cycle", ent_q[0], 1);
      chk("two_entry1_cycle", ent_q[1], 784);
    end
    if (ov_q.size() == 1) chk("two_ov_cycle", ov_q[0], 784);

    // dense frame
    clear_q();
    frame(2, 0, -1);
    @(negedge clk); #1;
    chk("dense_count", bus.feacture_valid_num, 784);
    chk("dense_slot0", bus.feacture_value[7:0], 8'h01);
    chk("dense_slot254", bus.feacture_value[254*W +: W], 8'hFF);
    chk("dense_slot255", bus.feacture_value[255*W +: W], 8'h01);
    chk("dense_slot783", bus.feacture_value[783*W +: W], 8'd19);
    chk("dense_row783", bus.feacture_rows[783*W +: W], 8'd27);
    chk("dense_col783", bus.feacture_cols[783*W +: W], 8'd27);
    chk("dense_entries", ent_q.size(), 784);

    // dense frame with ~30% bubbles
    clear_q();
    frame(2, 30, -1);
    @(negedge clk); #1;
    chk("bubble_out_valid", bus.out_valid, 1'b1);
    chk("bubble_count", bus.feacture_valid_num, 784);
    chk("bubble_ov_count", ov_q.size(), 1);

    // abort after 400 pixels, then the two-nonzero frame
    clear_q();
    frame(2, 0, 400);
    chk("abort_count", bus.feacture_valid_num, 0);
    frame(1, 0, -1);
    @(negedge clk); #1;
    chk("abort_ov_count", ov_q.size(), 1);
    chk("abort_two_count", bus.feacture_valid_num, 2);
    chk("abort_two_value", bus.feacture_value[31:0], 32'h0000_8005);

    // back-to-back dense then two-nonzero
    clear_q();
    frame(2, 0, -1);
    frame(1, 0, -1);
    @(negedge clk); #1;
    chk("b2b_ov_count", ov_q.size(), 2);
    chk("b2b_count", bus.feacture_valid_num, 2);
    chk("b2b_slot783", bus.feacture_value[783*W +: W], 8'h00);
    chk("b2b_row783", bus.feacture_rows[783*W +: W], 8'h00);

    // random sparse frames with bubbles
    frame(3, 20, -1);
    frame(3, 0, -1);
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
